// File: rtl/softmax_group_norm_if.sv
// Vector stream bundle for softmax_group_norm:
// input side (in_*) and normalised output side (out_*).
interface softmax_group_norm_if #(
  parameter int BW = 8,
  parameter int N  = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [BW*N-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BW*N-1:0] out_data;
  logic            out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/softmax_group_norm.sv
// LUT exp per lane, LSA/GSA exp-sum, sequential reciprocal,
// then normalised vectors streamed out under valid/ready.
module softmax_group_norm #(
  parameter int BW   = 8,
  parameter int N    = 8,
  parameter int G    = 8,
  parameter int EXPW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic            lut_wr_en,
  input  logic            lut_wr_msb,
  input  logic [BW/2-1:0] lut_wr_addr,
  input  logic [EXPW-1:0] lut_wr_data,
  output logic            lut_err,
  softmax_group_norm_if.slave s
);
  localparam int SUMW = EXPW + $clog2(N*G);
  localparam int RW   = EXPW + BW + 1;
  localparam int HW   = BW / 2;
  localparam int LD   = 1 << HW;
  localparam int IW   = (G > 1) ? $clog2(G) : 1;
  localparam int CW   = $clog2(G + 1);
  localparam int DW   = $clog2(RW);
  localparam int PW   = EXPW + RW;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, EMIT} state_t;

  state_t state, state_n;

  logic [EXPW-1:0]   lut_m [LD];
  logic [EXPW-1:0]   lut_l [LD];
  logic [EXPW-1:0]   ebuf  [G][N];
  logic [2*EXPW-1:0] pr    [N];
  logic [EXPW-1:0]   e     [N];
  logic [PW-1:0]     pp    [N];
  logic [PW-1:0]     sh    [N];
  logic [SUMW-1:0]   vsum, sum, rem;
  logic [SUMW:0]     trial;
  logic [RW-1:0]     dv, q;
  logic [DW-1:0]     dcnt;
  logic [CW-1:0]     cnt, nvec, ptr;
  logic [IW-1:0]     widx;
  logic [BW*N-1:0]   od;
  logic              mode_q, acc, close, ge, load, fin;

  always_comb begin
    vsum = '0;
    for (int i = 0; i < N; i++) begin
      pr[i] = (2*EXPW)'(lut_m[s.in_data[BW*i+HW +: HW]])
            * (2*EXPW)'(lut_l[s.in_data[BW*i +: HW]]);
      e[i]  = EXPW'(pr[i] >> EXPW);
      vsum  = vsum + SUMW'(e[i]);
    end
  end

  always_comb begin
    state_n    = state;
    s.in_ready = 1'b0;
    acc        = 1'b0;
    close      = 1'b0;
    unique case (state)
      IDLE: begin
        s.in_ready = 1'b1;
        acc   = s.in_valid;
        close = acc & (~mode | s.in_last | (G == 1));
        if (acc) state_n = close ? DIV : ACCUM;
      end
      ACCUM: begin
        s.in_ready = 1'b1;
        acc   = s.in_valid;
        close = acc & (~mode_q | s.in_last
              | (cnt == CW'(G - 1)));
        if (close) state_n = DIV;
      end
      DIV:
        if (dcnt == DW'(RW - 1)) state_n = EMIT;
      EMIT:
        if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign widx  = (state == IDLE) ? '0 : cnt[IW-1:0];
  assign trial = {rem, dv[RW-1]};
  assign ge    = trial >= {1'b0, sum};
  assign fin   = (state == EMIT) & s.out_valid
               & s.out_ready & s.out_last;
  assign load  = (state == EMIT) & (~s.out_valid
               | (s.out_ready & ~s.out_last));

  // Lane scale by the reciprocal, saturating to BW bits.
  always_comb begin
    od = '0;
    for (int i = 0; i < N; i++) begin
      pp[i] = PW'(ebuf[ptr[IW-1:0]][i]) * PW'(q);
      sh[i] = pp[i] >> EXPW;
      od[BW*i +: BW] = (|sh[i][PW-1:BW])
                     ? {BW{1'b1}} : sh[i][BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      for (int i = 0; i < N; i++) ebuf[widx][i] <= e[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sum         <= '0;
      mode_q      <= 1'b0;
      cnt         <= '0;
      nvec        <= '0;
      ptr         <= '0;
      rem         <= '0;
      dv          <= '0;
      q           <= '0;
      dcnt        <= '0;
      lut_err     <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
      s.out_data  <= '0;
      for (int i = 0; i < LD; i++) begin
        lut_m[i] <= '0;
        lut_l[i] <= '0;
      end
    end else begin
      state   <= state_n;
      lut_err <= lut_wr_en & (state != IDLE);
      if (lut_wr_en && state == IDLE) begin
        if (lut_wr_msb) lut_m[lut_wr_addr] <= lut_wr_data;
        else            lut_l[lut_wr_addr] <= lut_wr_data;
      end
      if (acc) begin
        if (state == IDLE) begin
          sum    <= vsum;
          mode_q <= mode;
          cnt    <= CW'(1);
        end else begin
          sum <= sum + vsum;
          cnt <= cnt + CW'(1);
        end
      end
      if (close) begin
        nvec <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
        rem  <= '0;
        dv   <= RW'(1) << (RW - 1);
        q    <= '0;
        dcnt <= '0;
      end
      if (state == DIV) begin
        rem  <= ge ? SUMW'(trial - {1'b0, sum})
                   : trial[SUMW-1:0];
        dv   <= dv << 1;
        dcnt <= dcnt + DW'(1);
        ptr  <= '0;
        // Zero sum yields an all-ones quotient; force it to 0.
        if (dcnt == DW'(RW - 1) && sum == '0) q <= '0;
        else q <= {q[RW-2:0], ge};
      end
      if (load) begin
        s.out_data  <= od;
        s.out_last  <= (ptr == nvec - CW'(1));
        s.out_valid <= 1'b1;
        ptr         <= ptr + CW'(1);
      end else if (fin) begin
        s.out_valid <= 1'b0;
        s.out_last  <= 1'b0;
      end
    end
  end
endmodule
